// File: rtl/mico8_xmem_arbiter.sv
// Round-robin arbiter sharing one synchronous BSRAM between the isp8 core
// external-memory bus and a debug/DMA requester, one access in flight.
module mico8_xmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

  state_t state_q, state_d;

  logic              gnt_dbg_q, gnt_dbg_d;
  logic              is_wr_q, is_wr_d;
  logic              prio_dbg_q, prio_dbg_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic              core_ready_q, core_ready_d;
  logic              dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic core_req;
  logic pick_dbg;

  assign core_req = core_rd | core_wr;
  assign pick_dbg = dbg_req & (~core_req | prio_dbg_q);

  always_comb begin
    state_d      = state_q;
    gnt_dbg_d    = gnt_dbg_q;
    is_wr_d      = is_wr_q;
    prio_dbg_d   = prio_dbg_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ce_d         = 1'b0;
    we_d         = 1'b0;
    core_ready_d = 1'b0;
    dbg_done_d   = 1'b0;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (core_req | dbg_req) begin
          gnt_dbg_d = pick_dbg;
          if (pick_dbg) begin
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
            is_wr_d = dbg_we;
          end else begin
            addr_d  = core_addr;
            wdata_d = core_wdata;
            // rd and wr together is treated as a read
            is_wr_d = core_wr & ~core_rd;
          end
          ce_d    = 1'b1;
          we_d    = is_wr_d;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = 2'd0;
        if (is_wr_q) begin
          core_ready_d = ~gnt_dbg_q;
          dbg_done_d   = gnt_dbg_q;
          state_d      = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          if (gnt_dbg_q) dbg_rdata_d = mem_rdata;
          else core_rdata_d = mem_rdata;
          core_ready_d = ~gnt_dbg_q;
          dbg_done_d   = gnt_dbg_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        // next contention goes to the requester not just served
        prio_dbg_d = ~gnt_dbg_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_dbg_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      prio_dbg_q   <= 1'b0;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      core_ready_q <= 1'b0;
      dbg_done_q   <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_dbg_q    <= gnt_dbg_d;
      is_wr_q      <= is_wr_d;
      prio_dbg_q   <= prio_dbg_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      core_ready_q <= core_ready_d;
      dbg_done_q   <= dbg_done_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign mem_ce     = ce_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_ready = core_ready_q;
  assign dbg_done   = dbg_done_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
